// File: rtl/early_debouncer_pkg.sv
// ============================================================================
// Module  : early_debouncer_pkg
// Purpose : Shared state encoding and default lockout length for early_debouncer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package early_debouncer_pkg;

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    LOCK1 = 2'd1,
    ONE   = 2'd2,
    LOCK0 = 2'd3
  } deb_state_t;

  localparam int unsigned DEF_LOCK_CYCLES = 1_000_000;

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module  : sync_2ff
// Purpose : Two-flop synchronizer for a single asynchronous level; resets to 0.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/early_debouncer.sv
// ============================================================================
// Module  : early_debouncer
// Purpose : Immediate-response debouncer: db follows the first edge, then holds
//           for LOCK_CYCLES clocks. Macro EARLY_DEBOUNCER_SYNC_EN adds a
//           2-flop input synchronizer (3-cycle sw-to-db latency).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module early_debouncer
  import early_debouncer_pkg::*;
#(
  parameter int unsigned LOCK_CYCLES = DEF_LOCK_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic sw,
  output logic db,
  output logic locked
);

  localparam int unsigned          CNT_W    = $clog2(LOCK_CYCLES);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

  logic sw_s;

`ifdef EARLY_DEBOUNCER_SYNC_EN
  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (sw),
    .q_o   (sw_s)
  );
`else
  assign sw_s = sw;
`endif

  deb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             db_q, db_d;
  logic             locked_q, locked_d;
  logic             expired;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    expired = (cnt_q == CNT_LAST);

    case (state_q)
      ZERO: begin
        if (sw_s) begin
          state_d = LOCK1;
          cnt_d   = '0;
        end
      end
      LOCK1: begin
        // Only the level present on the expiry cycle decides where we go.
        if (expired) begin
          cnt_d   = '0;
          state_d = sw_s ? ONE : LOCK0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ONE: begin
        if (!sw_s) begin
          state_d = LOCK0;
          cnt_d   = '0;
        end
      end
      LOCK0: begin
        if (expired) begin
          cnt_d   = '0;
          state_d = sw_s ? LOCK1 : ZERO;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ZERO;
        cnt_d   = '0;
      end
    endcase

    db_d     = (state_d == LOCK1) || (state_d == ONE);
    locked_d = (state_d == LOCK1) || (state_d == LOCK0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ZERO;
      cnt_q    <= '0;
      db_q     <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      db_q     <= db_d;
      locked_q <= locked_d;
    end
  end

  assign db     = db_q;
  assign locked = locked_q;

endmodule

`default_nettype wire

// File: tb/tb_early_debouncer.sv
// ============================================================================
// Module  : tb_early_debouncer
// Purpose : Self-checking bench for early_debouncer (LOCK_CYCLES = 8) with a
//           behavioural "time since last db change" reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_early_debouncer;

  localparam int L = 8;

  logic clk = 1'b0;
  logic reset;
  logic sw;
  logic db;
  logic locked;

  always #5 clk = ~clk;

  early_debouncer #(.LOCK_CYCLES(L)) dut (
    .clk    (clk),
    .reset  (reset),
    .sw     (sw),
    .db     (db),
    .locked (locked)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: db may only change once L clocks have elapsed since its last change.
  int   m_db  = 0;
  int   m_age = L;
  logic m_s1  = 1'b0;
  logic m_s2  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic s);
    logic s_eff;
    reset = r;
    sw    = s;
    @(posedge clk);
`ifdef EARLY_DEBOUNCER_SYNC_EN
    s_eff = m_s2;
    m_s2  = r ? 1'b0 : m_s1;
    m_s1  = r ? 1'b0 : s;
`else
    s_eff = s;
`endif
    if (r) begin
      m_db  = 0;
      m_age = L;
    end else begin
      if (m_age < L) m_age++;
      if (m_age == L && int'(s_eff) != m_db) begin
        m_db  = (m_db == 0) ? 1 : 0;
        m_age = 0;
      end
    end
    #1;
    check("db", 32'(db), 32'(m_db));
    check("locked", 32'(locked), (m_age < L) ? 32'd1 : 32'd0);
  endtask

  task automatic hold(input logic s, input int n);
    for (int i = 0; i < n; i++) step(1'b0, s);
  endtask

  initial begin
    reset = 1'b1;
    sw    = 1'b0;

    // Reset release with sw already high.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    hold(1'b1, 12);

    // Bouncy press from ZERO.
    hold(1'b0, 20);
    step(1'b0, 1'b1); step(1'b0, 1'b0); step(1'b0, 1'b1);
    step(1'b0, 1'b0); step(1'b0, 1'b1);
    hold(1'b1, 12);

    // Single-cycle glitch.
    hold(1'b0, 20);
    step(1'b0, 1'b1);
    hold(1'b0, 20);

    // sw drops exactly on the expiry cycle of LOCK1.
    step(1'b0, 1'b1);
    hold(1'b1, L - 1);
    step(1'b0, 1'b0);
    hold(1'b0, 20);

    // Reset in the middle of a lockout window.
    step(1'b0, 1'b1);
    hold(1'b1, 4);
    step(1'b1, 1'b1);
    hold(1'b0, 10);

    // Randomized bursts, holds and occasional resets.
    for (int seg = 0; seg < 300; seg++) begin
      int kind;
      kind = int'($urandom_range(0, 9));
      if (kind == 0) begin
        step(1'b1, 1'($urandom_range(0, 1)));
      end else if (kind <= 3) begin
        int n;
        n = int'($urandom_range(1, 12));
        for (int i = 0; i < n; i++) step(1'b0, 1'($urandom_range(0, 1)));
      end else begin
        hold(1'($urandom_range(0, 1)), int'($urandom_range(1, 25)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
